// File: rtl/regfile_scoreboard.sv
// General-purpose register file with two combinational read ports, one write port
// and a per-register pending-write scoreboard used by decode for RAW hazard detection.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              reg_write_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              issue_ready_o,
  output logic              any_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];

  logic writeEn;
  logic issueAccept;
  logic retireHitRs;
  logic retireHitRt;
  logic retireHitIssue;

  assign writeEn        = reg_write_i && (rd_addr_i != '0);
  assign retireHitRs    = reg_write_i && (rd_addr_i == rs_addr_i);
  assign retireHitRt    = reg_write_i && (rd_addr_i == rt_addr_i);
  assign retireHitIssue = reg_write_i && (rd_addr_i == issue_addr_i);

  // A full counter can still accept an issue when a retire frees a slot this cycle.
  assign issue_ready_o = (issue_addr_i == '0) || (cnt_q[issue_addr_i] != CNT_MAX) || retireHitIssue;
  assign issueAccept   = issue_valid_i && issue_ready_o && (issue_addr_i != '0);

  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
    rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
    if (BYPASS && writeEn && (rd_addr_i == rs_addr_i)) rs_data_o = rd_data_i;
    if (BYPASS && writeEn && (rd_addr_i == rt_addr_i)) rt_data_o = rd_data_i;
  end

  // With bypass, a retiring write already counts as landed; compare instead of subtract
  // so an untracked write to an idle register never looks busy.
  always_comb begin
    if (BYPASS) begin
      rs_busy_o = cnt_q[rs_addr_i] > CNT_W'(retireHitRs);
      rt_busy_o = cnt_q[rt_addr_i] > CNT_W'(retireHitRt);
    end else begin
      rs_busy_o = cnt_q[rs_addr_i] != '0;
      rt_busy_o = cnt_q[rt_addr_i] != '0;
    end
  end

  always_comb begin
    any_busy_o = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      any_busy_o = any_busy_o | (cnt_q[r] != '0);
    end
  end

  // Issue and retire on the same register cancel; retire alone saturates at zero.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issueAccept && (issue_addr_i == ADDR_W'(r)) &&
          !(reg_write_i && (rd_addr_i == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (reg_write_i && (rd_addr_i == ADDR_W'(r)) &&
                   !(issueAccept && (issue_addr_i == ADDR_W'(r))) &&
                   (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      if (writeEn) regs_q[rd_addr_i] <= rd_data_i;
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule
